// File: rtl/jc_pkg.sv
// Shared definitions for the jump control unit: opcodes, flag bit positions and FSM states.
package jc_pkg;

   // Branch opcodes, decoded on op[5:0]
   localparam logic [5:0] OP_JMP = 6'h18;
   localparam logic [5:0] OP_RET = 6'h10;
   localparam logic [5:0] OP_JV  = 6'h1C;
   localparam logic [5:0] OP_JNV = 6'h1D;
   localparam logic [5:0] OP_JZ  = 6'h1E;
   localparam logic [5:0] OP_JNZ = 6'h1F;

   // Flag bit positions within flag_ex
   localparam int unsigned FLAG_V = 0;
   localparam int unsigned FLAG_Z = 1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPending = 2'd1,
      StEntry   = 2'd2
   } jc_state_t;

endpackage

// File: rtl/ret_stack.sv
// Return stack: LIFO of {return address, saved flags}; no wrap-around, level saturates at DEPTH.
module ret_stack #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 18
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_W-1:0]            din,
   output logic [DATA_W-1:0]            dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [LVL_W-1:0]  level_q;
   logic [LVL_W-1:0]  top_lvl;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign top_lvl = level_q - LVL_W'(1);
   // Index narrowing is safe: writes only happen below full, reads only above empty
   assign wr_idx  = level_q[IDX_W-1:0];
   assign rd_idx  = top_lvl[IDX_W-1:0];
   assign dout    = empty ? '0 : mem_q[rd_idx];
   assign level   = level_q;

   // Storage and occupancy; push is ignored when full, pop when empty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !full) begin
         mem_q[wr_idx] <= din;
         level_q       <= level_q + LVL_W'(1);
      end else if (pop && !empty) begin
         level_q <= level_q - LVL_W'(1);
      end
   end

endmodule

// File: rtl/jump_ctrl_unit.sv
// Fetch-stage jump control: branch decode, synchronised interrupt entry and nested return stack.
module jump_ctrl_unit #(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       OP_W        = 6,
   parameter int unsigned       FLAG_W      = 2,
   parameter int unsigned       STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] INT_VECTOR  = 'hF000,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [ADDR_W-1:0]                  jmp_address_pm,
   input  logic [ADDR_W-1:0]                  current_address,
   input  logic [OP_W-1:0]                    op,
   input  logic [FLAG_W-1:0]                  flag_ex,
   input  logic                               interrupt,
   output logic [ADDR_W-1:0]                  jmp_loc,
   output logic                               pc_mux_sel,
   output logic                               int_ack,
   output logic [FLAG_W-1:0]                  restored_flags,
   output logic                               flag_restore,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
   output logic                               stack_overflow,
   output logic                               stack_underflow
);

   import jc_pkg::*;

   localparam int unsigned DATA_W = ADDR_W + FLAG_W;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   valid_q;
   logic                   edge_q;
   logic                   int_req;

   jc_state_t state_q, state_d;
   logic      ovf_q, unf_q;
   logic      set_ovf, set_unf;

   logic              push, pop;
   logic              stk_full, stk_empty;
   logic [DATA_W-1:0] stk_dout;
   logic [5:0]        op6;
   logic              is_ret;
   logic              taken;

   assign op6    = op[5:0];
   assign is_ret = (op6 == OP_RET);

   // valid_q marks which synchroniser/edge stages hold real post-reset samples, so a level
   // already high at reset release is not mistaken for a rising edge
   assign int_req = sync_q[SYNC_STAGES-1] & ~edge_q & valid_q[SYNC_STAGES];

   // Interrupt synchroniser and edge register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         valid_q <= '0;
         edge_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], interrupt};
         valid_q <= {valid_q[SYNC_STAGES-1:0], 1'b1};
         edge_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   // FSM state and sticky error flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (set_ovf) ovf_q <= 1'b1;
         if (set_unf) unf_q <= 1'b1;
      end
   end

   // Branch condition decode on execute flags
   always_comb begin
      taken = 1'b0;
      case (op6)
         OP_JMP:  taken = 1'b1;
         OP_JV:   taken = flag_ex[FLAG_V];
         OP_JNV:  taken = ~flag_ex[FLAG_V];
         OP_JZ:   taken = flag_ex[FLAG_Z];
         OP_JNZ:  taken = ~flag_ex[FLAG_Z];
         default: taken = 1'b0;
      endcase
   end

   // Next state, stack control and PC redirect outputs
   always_comb begin
      state_d        = state_q;
      set_ovf        = 1'b0;
      set_unf        = 1'b0;
      push           = 1'b0;
      pop            = 1'b0;
      pc_mux_sel     = 1'b0;
      jmp_loc        = jmp_address_pm;
      int_ack        = 1'b0;
      flag_restore   = 1'b0;
      restored_flags = '0;

      case (state_q)
         StEntry: begin
            // Annul the instruction in decode and vector; its own PC is saved for re-execution
            pc_mux_sel = 1'b1;
            jmp_loc    = INT_VECTOR;
            int_ack    = 1'b1;
            push       = 1'b1;
            state_d    = StIdle;
         end
         StIdle, StPending: begin
            if (is_ret) begin
               if (!stk_empty) begin
                  pop            = 1'b1;
                  pc_mux_sel     = 1'b1;
                  jmp_loc        = stk_dout[DATA_W-1:FLAG_W];
                  restored_flags = stk_dout[FLAG_W-1:0];
                  flag_restore   = 1'b1;
               end else begin
                  set_unf = 1'b1;
               end
            end else if (taken) begin
               pc_mux_sel = 1'b1;
            end

            if (state_q == StIdle) begin
               if (int_req) begin
                  // A RET pops this cycle, so entry is deferred rather than colliding with it
                  if (is_ret) begin
                     state_d = StPending;
                  end else if (stk_full) begin
                     set_ovf = 1'b1;
                  end else begin
                     state_d = StEntry;
                  end
               end
            end else if (!is_ret) begin
               if (stk_full) begin
                  set_ovf = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StEntry;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (!reset) begin
         pc_mux_sel     = 1'b0;
         jmp_loc        = '0;
         int_ack        = 1'b0;
         flag_restore   = 1'b0;
         restored_flags = '0;
      end
   end

   assign stack_overflow  = ovf_q;
   assign stack_underflow = unf_q;

   ret_stack #(
      .DEPTH  (STACK_DEPTH),
      .DATA_W (DATA_W)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   ({current_address, flag_ex}),
      .dout  (stk_dout),
      .level (stack_level),
      .full  (stk_full),
      .empty (stk_empty)
   );

endmodule

// File: tb/tb_jump_ctrl_unit.sv
// Directed bench for jump_ctrl_unit: decode table plus interrupt/stack/reset sequences.
module tb_jump_ctrl_unit;

   logic        clk;
   logic        reset;
   logic [15:0] jmp_address_pm;
   logic [15:0] current_address;
   logic [5:0]  op;
   logic [1:0]  flag_ex;
   logic        interrupt;
   logic [15:0] jmp_loc;
   logic        pc_mux_sel;
   logic        int_ack;
   logic [1:0]  restored_flags;
   logic        flag_restore;
   logic [2:0]  stack_level;
   logic        stack_overflow;
   logic        stack_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   jump_ctrl_unit dut (
      .clk             (clk),
      .reset           (reset),
      .jmp_address_pm  (jmp_address_pm),
      .current_address (current_address),
      .op              (op),
      .flag_ex         (flag_ex),
      .interrupt       (interrupt),
      .jmp_loc         (jmp_loc),
      .pc_mux_sel      (pc_mux_sel),
      .int_ack         (int_ack),
      .restored_flags  (restored_flags),
      .flag_restore    (flag_restore),
      .stack_level     (stack_level),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [1:0]  flag;
      logic [15:0] addr;
      logic        exp_sel;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a rising edge; raises interrupt and checks the would-be ENTRY cycle
   task automatic fire_int(input logic [15:0] a, input logic [1:0] f, input logic exp_ack);
      interrupt       = 1'b1;
      current_address = a;
      flag_ex         = f;
      op              = 6'h00;
      repeat (3) @(posedge clk);
      #1;
      check("entry_int_ack", 32'(int_ack), 32'(exp_ack));
      if (exp_ack) begin
         check("entry_jmp_loc", 32'(jmp_loc), 32'hF000);
         check("entry_pc_sel", 32'(pc_mux_sel), 32'd1);
      end
      @(posedge clk);
      #1;
      interrupt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{op: 6'h1E, flag: 2'b10, addr: 16'h0040, exp_sel: 1'b1};
      vecs[1]  = '{op: 6'h1E, flag: 2'b00, addr: 16'h0040, exp_sel: 1'b0};
      vecs[2]  = '{op: 6'h1F, flag: 2'b00, addr: 16'h0041, exp_sel: 1'b1};
      vecs[3]  = '{op: 6'h1F, flag: 2'b10, addr: 16'h0042, exp_sel: 1'b0};
      vecs[4]  = '{op: 6'h1C, flag: 2'b01, addr: 16'h0043, exp_sel: 1'b1};
      vecs[5]  = '{op: 6'h1C, flag: 2'b10, addr: 16'h0044, exp_sel: 1'b0};
      vecs[6]  = '{op: 6'h1D, flag: 2'b10, addr: 16'h0045, exp_sel: 1'b1};
      vecs[7]  = '{op: 6'h1D, flag: 2'b11, addr: 16'h0046, exp_sel: 1'b0};
      vecs[8]  = '{op: 6'h18, flag: 2'b00, addr: 16'h0047, exp_sel: 1'b1};
      vecs[9]  = '{op: 6'h00, flag: 2'b11, addr: 16'h0048, exp_sel: 1'b0};
      vecs[10] = '{op: 6'h3F, flag: 2'b11, addr: 16'h0049, exp_sel: 1'b0};

      // Reset state, with inputs that would redirect if not gated
      reset           = 1'b0;
      interrupt       = 1'b0;
      op              = 6'h18;
      flag_ex         = 2'b00;
      jmp_address_pm  = 16'h1234;
      current_address = 16'h0000;
      #3;
      check("rst_pc_sel", 32'(pc_mux_sel), 32'd0);
      check("rst_jmp_loc", 32'(jmp_loc), 32'd0);
      check("rst_int_ack", 32'(int_ack), 32'd0);
      check("rst_level", 32'(stack_level), 32'd0);
      check("rst_ovf", 32'(stack_overflow), 32'd0);
      check("rst_unf", 32'(stack_underflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      op    = 6'h00;
      repeat (5) @(posedge clk);
      #1;

      // Branch decode table
      for (int i = 0; i < 11; i++) begin
         op             = vecs[i].op;
         flag_ex        = vecs[i].flag;
         jmp_address_pm = vecs[i].addr;
         #2;
         check($sformatf("dec%0d_sel", i), 32'(pc_mux_sel), 32'(vecs[i].exp_sel));
         check($sformatf("dec%0d_loc", i), 32'(jmp_loc), 32'(vecs[i].addr));
         check($sformatf("dec%0d_frst", i), 32'(flag_restore), 32'd0);
         @(posedge clk);
         #1;
      end
      op = 6'h00;

      // Interrupt entry then RET
      fire_int(16'h0123, 2'b01, 1'b1);
      check("ent_level", 32'(stack_level), 32'd1);
      op = 6'h10;
      #1;
      check("ret_sel", 32'(pc_mux_sel), 32'd1);
      check("ret_loc", 32'(jmp_loc), 32'h0123);
      check("ret_flags", 32'(restored_flags), 32'b01);
      check("ret_frst", 32'(flag_restore), 32'd1);
      @(posedge clk);
      #1;
      op = 6'h00;
      check("ret_level", 32'(stack_level), 32'd0);

      // RET colliding with an interrupt request
      fire_int(16'h0200, 2'b10, 1'b1);
      interrupt       = 1'b1;
      current_address = 16'h0300;
      flag_ex         = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      op = 6'h10;
      #1;
      check("col_ret_loc", 32'(jmp_loc), 32'h0200);
      check("col_ret_flags", 32'(restored_flags), 32'b10);
      check("col_ret_frst", 32'(flag_restore), 32'd1);
      @(posedge clk);
      #1;
      op = 6'h00;
      check("col_pend_ack", 32'(int_ack), 32'd0);
      check("col_pend_level", 32'(stack_level), 32'd0);
      @(posedge clk);
      #1;
      check("col_entry_ack", 32'(int_ack), 32'd1);
      check("col_entry_loc", 32'(jmp_loc), 32'hF000);
      @(posedge clk);
      #1;
      interrupt = 1'b0;
      check("col_after_ack", 32'(int_ack), 32'd0);
      check("col_level", 32'(stack_level), 32'd1);
      op = 6'h10;
      #1;
      check("col_ret2_loc", 32'(jmp_loc), 32'h0300);
      @(posedge clk);
      #1;
      op = 6'h00;
      check("col_ret2_level", 32'(stack_level), 32'd0);
      repeat (3) @(posedge clk);
      #1;

      // Nesting up to full, then one dropped interrupt
      for (int i = 0; i < 4; i++) begin
         fire_int(16'h1000 + 16'(i), 2'(i), 1'b1);
      end
      check("nest_level", 32'(stack_level), 32'd4);
      check("nest_ovf_pre", 32'(stack_overflow), 32'd0);
      fire_int(16'h1004, 2'b00, 1'b0);
      check("nest_ovf", 32'(stack_overflow), 32'd1);
      check("nest_level_full", 32'(stack_level), 32'd4);
      for (int i = 3; i >= 0; i--) begin
         op = 6'h10;
         #1;
         check($sformatf("pop%0d_loc", i), 32'(jmp_loc), 32'h1000 + 32'(i));
         check($sformatf("pop%0d_flags", i), 32'(restored_flags), 32'(i));
         @(posedge clk);
         #1;
      end
      op = 6'h00;
      check("pop_level", 32'(stack_level), 32'd0);

      // Underflow
      jmp_address_pm = 16'h0555;
      op             = 6'h10;
      #1;
      check("unf_sel", 32'(pc_mux_sel), 32'd0);
      check("unf_loc", 32'(jmp_loc), 32'h0555);
      check("unf_frst", 32'(flag_restore), 32'd0);
      @(posedge clk);
      #1;
      op = 6'h00;
      check("unf_flag", 32'(stack_underflow), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("unf_sticky", 32'(stack_underflow), 32'd1);
      check("ovf_sticky", 32'(stack_overflow), 32'd1);

      // Async reset in the middle of ENTRY, interrupt held high through release
      interrupt       = 1'b1;
      current_address = 16'h0777;
      repeat (3) @(posedge clk);
      #1;
      check("mid_entry_ack", 32'(int_ack), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_sel", 32'(pc_mux_sel), 32'd0);
      check("arst_ack", 32'(int_ack), 32'd0);
      check("arst_level", 32'(stack_level), 32'd0);
      check("arst_unf", 32'(stack_underflow), 32'd0);
      check("arst_ovf", 32'(stack_overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("no_spur_ack%0d", i), 32'(int_ack), 32'd0);
      end
      check("no_spur_level", 32'(stack_level), 32'd0);
      interrupt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      fire_int(16'h0888, 2'b11, 1'b1);
      check("post_rst_level", 32'(stack_level), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
